// File: rtl/fc_alu_feeder_if.sv
// Bus bundle between the fully-connected ALU feeder and its environment:
// layer control, read-only memory port, ALU drive/result and result stream.
interface fc_alu_feeder_if #(
  parameter int unsigned SIZE     = 16,
  parameter int unsigned INPUT_SZ = 2,
  parameter int unsigned ADDR_W   = 16
);
  // Layer control
  logic                           start;
  logic [ADDR_W-1:0]              in_base;
  logic [ADDR_W-1:0]              w_base;
  logic                           busy;
  logic                           done;
  // Memory read port
  logic                           mem_rd;
  logic [ADDR_W-1:0]              mem_addr;
  logic [SIZE-1:0]                mem_data;
  logic                           mem_valid;
  // ALU drive and result
  logic [INPUT_SZ:0][SIZE-1:0]    alu_values;
  logic [1:0]                     alu_load_enable;
  logic                           alu_clear;
  logic                           alu_enable;
  logic [SIZE-1:0]                alu_value;
  // Result stream
  logic [SIZE-1:0]                out_data;
  logic                           out_valid;
  logic                           out_ready;

  // Feeder side
  modport master (
    input  start, in_base, w_base, mem_data, mem_valid, alu_value, out_ready,
    output busy, done, mem_rd, mem_addr, alu_values, alu_load_enable, alu_clear,
    alu_enable, out_data, out_valid
  );

  // Environment side (memory, ALU, downstream, controller)
  modport slave (
    output start, in_base, w_base, mem_data, mem_valid, alu_value, out_ready,
    input  busy, done, mem_rd, mem_addr, alu_values, alu_load_enable, alu_clear,
    alu_enable, out_data, out_valid
  );
endinterface

// File: rtl/fc_alu_feeder.sv
// Sequencer feeding one fully-connected layer into the ALU: fetches the input
// vector once, then for each neuron fetches bias/weights, loads, clears and
// fires the ALU, captures the result and streams it out over valid/ready.
// Optional build macro FC_FEEDER_RELU_EN: clamp negative results to zero.
module fc_alu_feeder #(
  parameter int unsigned SIZE      = 16,
  parameter int unsigned PRECISION = 11,
  parameter int unsigned INPUT_SZ  = 2,
  parameter int unsigned N_OUT     = 4,
  parameter int unsigned ADDR_W    = 16
) (
  input logic            clk,
  input logic            reset,
  fc_alu_feeder_if.master bus
);

  localparam int unsigned KW = $clog2(INPUT_SZ + 1);
  localparam int unsigned JW = (N_OUT > 1) ? $clog2(N_OUT) : 1;

  // Fraction bits are interpretation only; reject nonsensical formats.
  if (PRECISION >= SIZE) begin : gen_bad_precision
    $error("PRECISION must be smaller than SIZE");
  end

  localparam logic [3:0] StIdle    = 4'd0;
  localparam logic [3:0] StFetchIn = 4'd1;
  localparam logic [3:0] StLoadIn  = 4'd2;
  localparam logic [3:0] StFetchW  = 4'd3;
  localparam logic [3:0] StLoadW   = 4'd4;
  localparam logic [3:0] StClear   = 4'd5;
  localparam logic [3:0] StCompute = 4'd6;
  localparam logic [3:0] StWaitRes = 4'd7;
  localparam logic [3:0] StOutput  = 4'd8;
  localparam logic [3:0] StDone    = 4'd9;

  localparam logic [1:0] LoadValues      = 2'd0;
  localparam logic [1:0] LoadBiasWeights = 2'd1;
  localparam logic [1:0] LoadUd          = 2'd2;

  logic [3:0]                  state_q, state_d;
  logic [KW-1:0]               k_q, k_d;
  logic [JW-1:0]               j_q, j_d;
  logic [ADDR_W-1:0]           in_base_q, in_base_d;
  logic [ADDR_W-1:0]           row_base_q, row_base_d;
  logic [INPUT_SZ:0][SIZE-1:0] values_q, values_d;
  logic [SIZE-1:0]             out_data_q, out_data_d;
  logic [KW-1:0]               slot_idx;

  // Next-state: FSM, word/neuron counters, captured memory words and result
  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    j_d        = j_q;
    in_base_d  = in_base_q;
    row_base_d = row_base_q;
    values_d   = values_q;
    out_data_d = out_data_q;
    slot_idx   = k_q + KW'(1);

    case (state_q)
      StIdle: begin
        if (bus.start) begin
          in_base_d  = bus.in_base;
          row_base_d = bus.w_base;
          k_d        = '0;
          j_d        = '0;
          state_d    = StFetchIn;
        end
      end
      StFetchIn: begin
        // Inputs land in slots 1..INPUT_SZ; slot 0 carries zero during LOAD_IN.
        if (bus.mem_valid) begin
          values_d[slot_idx] = bus.mem_data;
          if (k_q == '0) values_d[0] = '0;
          if (k_q == KW'(INPUT_SZ - 1)) begin
            k_d     = '0;
            state_d = StLoadIn;
          end else begin
            k_d = k_q + KW'(1);
          end
        end
      end
      StLoadIn:  state_d = StFetchW;
      StFetchW: begin
        // Row word k: bias in slot 0, weights in slots 1..INPUT_SZ.
        if (bus.mem_valid) begin
          values_d[k_q] = bus.mem_data;
          if (k_q == KW'(INPUT_SZ)) begin
            k_d     = '0;
            state_d = StLoadW;
          end else begin
            k_d = k_q + KW'(1);
          end
        end
      end
      StLoadW:   state_d = StClear;
      StClear:   state_d = StCompute;
      StCompute: state_d = StWaitRes;
      StWaitRes: begin
`ifdef FC_FEEDER_RELU_EN
        out_data_d = bus.alu_value[SIZE-1] ? '0 : bus.alu_value;
`else
        out_data_d = bus.alu_value;
`endif
        state_d = StOutput;
      end
      StOutput: begin
        if (bus.out_ready) begin
          if (j_q == JW'(N_OUT - 1)) begin
            state_d = StDone;
          end else begin
            j_d        = j_q + JW'(1);
            row_base_d = row_base_q + ADDR_W'(INPUT_SZ + 1);
            k_d        = '0;
            state_d    = StFetchW;
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State registers; reset aborts any layer and drops an outstanding read
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      k_q        <= '0;
      j_q        <= '0;
      in_base_q  <= '0;
      row_base_q <= '0;
      values_q   <= '0;
      out_data_q <= '0;
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      j_q        <= j_d;
      in_base_q  <= in_base_d;
      row_base_q <= row_base_d;
      values_q   <= values_d;
      out_data_q <= out_data_d;
    end
  end

  // Outputs decoded from the current state; request held until mem_valid
  always_comb begin
    bus.mem_rd          = (state_q == StFetchIn) || (state_q == StFetchW);
    bus.mem_addr        = '0;
    bus.alu_load_enable = LoadUd;
    bus.alu_clear       = (state_q == StClear);
    bus.alu_enable      = (state_q == StCompute);
    bus.alu_values      = values_q;
    bus.out_data        = out_data_q;
    bus.out_valid       = (state_q == StOutput);
    bus.busy            = (state_q != StIdle) && (state_q != StDone);
    bus.done            = (state_q == StDone);

    case (state_q)
      StFetchIn: bus.mem_addr = in_base_q + ADDR_W'(k_q);
      StFetchW:  bus.mem_addr = row_base_q + ADDR_W'(k_q);
      default:   bus.mem_addr = '0;
    endcase

    case (state_q)
      StLoadIn:                    bus.alu_load_enable = LoadValues;
      StLoadW, StClear, StCompute: bus.alu_load_enable = LoadBiasWeights;
      default:                     bus.alu_load_enable = LoadUd;
    endcase
  end

endmodule

// File: tb/tb_fc_alu_feeder.sv
// Directed bench for fc_alu_feeder: behavioural fixed-point ALU and a
// read-only memory with programmable wait states around the feeder.
module tb_fc_alu_feeder;

  localparam int unsigned SIZE      = 16;
  localparam int unsigned PRECISION = 11;
  localparam int unsigned INPUT_SZ  = 2;
  localparam int unsigned N_OUT     = 2;
  localparam int unsigned ADDR_W    = 16;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fc_alu_feeder_if #(.SIZE(SIZE), .INPUT_SZ(INPUT_SZ), .ADDR_W(ADDR_W)) bus ();

  fc_alu_feeder #(
    .SIZE(SIZE), .PRECISION(PRECISION), .INPUT_SZ(INPUT_SZ), .N_OUT(N_OUT), .ADDR_W(ADDR_W)
  ) u_dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Memory with wait states
  logic [15:0] mem [64];
  int wait_cycles;
  int wait_cnt;
  assign bus.mem_valid = bus.mem_rd && (wait_cnt == wait_cycles);
  assign bus.mem_data  = mem[bus.mem_addr[5:0]];

  always @(posedge clk or posedge reset) begin
    if (reset) wait_cnt <= 0;
    else if (bus.mem_rd && !bus.mem_valid) wait_cnt <= wait_cnt + 1;
    else wait_cnt <= 0;
  end

  // Read counters and request-stability monitor, sampled mid-cycle
  int rd_count = 0;
  int in_reads = 0;
  int unstable = 0;
  logic prev_pending = 1'b0;
  logic [15:0] prev_addr = '0;
  always @(negedge clk) begin
    if (!reset && bus.mem_rd && bus.mem_valid) begin
      rd_count = rd_count + 1;
      if (bus.mem_addr == 16'h10 || bus.mem_addr == 16'h11) in_reads = in_reads + 1;
    end
    if (prev_pending && !reset && (!bus.mem_rd || bus.mem_addr != prev_addr))
      unstable = unstable + 1;
    prev_pending = bus.mem_rd && !bus.mem_valid && !reset;
    prev_addr    = bus.mem_addr;
  end

  // Behavioural ALU: acc = bias + sum(w*x) in Q5.11
  logic signed [15:0] ax [2];
  logic signed [15:0] aw [2];
  logic signed [15:0] ab;
  logic signed [15:0] acc;
  assign bus.alu_value = acc;

  function automatic logic signed [15:0] alu_eval();
    logic signed [31:0] s;
    logic signed [31:0] a;
    logic signed [31:0] b;
    s = 0;
    for (int i = 0; i < 2; i++) begin
      a = aw[i];
      b = ax[i];
      s = s + ((a * b) >>> 11);
    end
    return ab + s[15:0];
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 2; i++) begin
        ax[i] <= '0;
        aw[i] <= '0;
      end
      ab  <= '0;
      acc <= '0;
    end else begin
      if (bus.alu_load_enable == 2'd0) begin
        for (int i = 0; i < 2; i++) ax[i] <= bus.alu_values[i+1];
      end else if (bus.alu_load_enable == 2'd1) begin
        ab <= bus.alu_values[0];
        for (int i = 0; i < 2; i++) aw[i] <= bus.alu_values[i+1];
      end
      if (bus.alu_clear) acc <= '0;
      else if (bus.alu_enable) acc <= alu_eval();
    end
  end

  task automatic do_start(input logic [15:0] ib, input logic [15:0] wb);
    @(negedge clk);
    bus.in_base = ib;
    bus.w_base  = wb;
    bus.start   = 1'b1;
  endtask

  // Counts cycles until out_valid; n is the cycle index of the first valid cycle.
  task automatic wait_valid(input bit chk, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
      bus.start = 1'b0;
      if (chk) begin
        if (n == 3) check("ld_in_mode", 32'(bus.alu_load_enable), 32'd0);
        if (n == 3) check("ld_in_slot0", 32'(bus.alu_values[0]), 32'h0);
        if (n == 7) check("ld_w_mode", 32'(bus.alu_load_enable), 32'd1);
        if (n == 8) check("clear", 32'(bus.alu_clear), 32'd1);
        if (n == 9) check("enable", 32'(bus.alu_enable), 32'd1);
      end
    end while (!bus.out_valid && n < 200);
  endtask

  task automatic check_reset_vals(input string p);
    check({p, "_mem_rd"}, 32'(bus.mem_rd), 32'd0);
    check({p, "_mem_addr"}, 32'(bus.mem_addr), 32'd0);
    check({p, "_alu_values"}, 32'(bus.alu_values == '0), 32'd1);
    check({p, "_load_en"}, 32'(bus.alu_load_enable), 32'd2);
    check({p, "_clear"}, 32'(bus.alu_clear), 32'd0);
    check({p, "_enable"}, 32'(bus.alu_enable), 32'd0);
    check({p, "_out_data"}, 32'(bus.out_data), 32'd0);
    check({p, "_out_valid"}, 32'(bus.out_valid), 32'd0);
    check({p, "_busy"}, 32'(bus.busy), 32'd0);
    check({p, "_done"}, 32'(bus.done), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int rd0;
    int in0;
    int bad0;
    int hold_bad;

    for (int i = 0; i < 64; i++) mem[i] = '0;
    mem[6'h10] = 16'h0800;  // input 0 = 1.0
    mem[6'h11] = 16'h0400;  // input 1 = 0.5
    mem[6'h20] = 16'h0C00;  // neuron 0 bias 1.5
    mem[6'h21] = 16'h1800;  // w 3.0
    mem[6'h22] = 16'h2000;  // w 4.0  -> 1.5 + 3.0 + 2.0 = 6.5
    mem[6'h23] = 16'h0800;  // neuron 1 bias 1.0
    mem[6'h24] = 16'h0800;
    mem[6'h25] = 16'h0800;  // -> 1.0 + 1.0 + 0.5 = 2.5

    wait_cycles   = 0;
    reset         = 1'b1;
    bus.start     = 1'b0;
    bus.in_base   = '0;
    bus.w_base    = '0;
    bus.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_vals("rst");
    reset = 1'b0;

    // A: zero-wait memory, downstream always ready
    rd0 = rd_count;
    do_start(16'h10, 16'h20);
    wait_valid(1'b1, n);
    check("a_lat0", 32'(n), 32'd11);
    check("a_n0", 32'(bus.out_data), 32'h3400);
    check("a_mode_out", 32'(bus.alu_load_enable), 32'd2);
    check("a_busy", 32'(bus.busy), 32'd1);
    wait_valid(1'b0, n);
    check("a_lat1", 32'(n), 32'd8);
    check("a_n1", 32'(bus.out_data), 32'h1400);
    @(negedge clk);
    check("a_done", 32'(bus.done), 32'd1);
    check("a_busy_done", 32'(bus.busy), 32'd0);
    @(negedge clk);
    check("a_done_pulse", 32'(bus.done), 32'd0);
    check("a_reads", 32'(rd_count - rd0), 32'd8);

    // B: three wait states per read
    wait_cycles = 3;
    rd0  = rd_count;
    in0  = in_reads;
    bad0 = unstable;
    do_start(16'h10, 16'h20);
    wait_valid(1'b0, n);
    check("b_lat0", 32'(n), 32'd26);
    check("b_n0", 32'(bus.out_data), 32'h3400);
    wait_valid(1'b0, n);
    check("b_lat1", 32'(n), 32'd17);
    check("b_n1", 32'(bus.out_data), 32'h1400);
    @(negedge clk);
    check("b_done", 32'(bus.done), 32'd1);
    check("b_reads", 32'(rd_count - rd0), 32'd8);
    check("b_in_reads", 32'(in_reads - in0), 32'd2);
    check("b_addr_stable", 32'(unstable - bad0), 32'd0);

    // C: downstream stalls neuron 0 for five cycles
    wait_cycles   = 0;
    bus.out_ready = 1'b0;
    do_start(16'h10, 16'h20);
    wait_valid(1'b0, n);
    check("c_lat0", 32'(n), 32'd11);
    rd0      = rd_count;
    hold_bad = 0;
    repeat (5) begin
      @(negedge clk);
      if (!(bus.out_valid && bus.out_data == 16'h3400)) hold_bad++;
    end
    check("c_hold", 32'(hold_bad), 32'd0);
    check("c_no_reads", 32'(rd_count - rd0), 32'd0);
    bus.out_ready = 1'b1;
    wait_valid(1'b0, n);
    check("c_lat1", 32'(n), 32'd8);
    check("c_n1", 32'(bus.out_data), 32'h1400);
    @(negedge clk);
    check("c_done", 32'(bus.done), 32'd1);

    // D: negative result (bias -2.0, zero weights) on neuron 1
    mem[6'h23] = 16'hF000;
    mem[6'h24] = 16'h0000;
    mem[6'h25] = 16'h0000;
    do_start(16'h10, 16'h20);
    wait_valid(1'b0, n);
    check("d_n0", 32'(bus.out_data), 32'h3400);
    wait_valid(1'b0, n);
`ifdef FC_FEEDER_RELU_EN
    check("d_relu", 32'(bus.out_data), 32'h0000);
`else
    check("d_neg", 32'(bus.out_data), 32'hF000);
`endif
    @(negedge clk);
    check("d_done", 32'(bus.done), 32'd1);

    // E: ignored start while busy, then reset during FETCH_W
    do_start(16'h10, 16'h20);
    @(negedge clk);                       // cycle 1
    bus.start = 1'b0;
    @(negedge clk);                       // cycle 2
    bus.in_base = 16'h30;
    bus.w_base  = 16'h30;
    bus.start   = 1'b1;
    @(negedge clk);                       // cycle 3
    bus.start = 1'b0;
    check("e_busy", 32'(bus.busy), 32'd1);
    @(negedge clk);                       // cycle 4: first row read
    check("e_rd", 32'(bus.mem_rd), 32'd1);
    check("e_no_relatch", 32'(bus.mem_addr), 32'h20);
    reset = 1'b1;
    #1;
    check_reset_vals("e_rst");
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("e_idle_busy", 32'(bus.busy), 32'd0);
    do_start(16'h10, 16'h20);
    wait_valid(1'b0, n);
    check("e_lat0", 32'(n), 32'd11);
    check("e_n0", 32'(bus.out_data), 32'h3400);
    wait_valid(1'b0, n);
    @(negedge clk);
    check("e_done", 32'(bus.done), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
